// File: rtl/mx_block_scaler.sv
// Collects one MX block, finds the shared exponent (max exponent over nonzero
// mantissas), then replays each element with its right-shift amount.
module mx_block_scaler #(
  parameter int block_size  = 32,
  parameter int width_exp   = 8,
  parameter int width_man   = 9,
  parameter int width_shift = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [width_exp-1:0]   i_exp,
  input  logic [width_man-1:0]   i_man,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [width_man-1:0]   o_man,
  output logic [width_shift-1:0] o_shift,
  output logic [width_exp-1:0]   o_scale,
  output logic                   o_last
);

  localparam int cnt_w = $clog2(block_size);
  localparam logic [cnt_w-1:0] last_idx = cnt_w'(block_size - 1);
  localparam logic [31:0] shift_max = (32'd1 << width_shift) - 32'd1;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                 ready_q;
  logic                 valid_q;
  logic [cnt_w-1:0]     wr_cnt;
  logic [cnt_w-1:0]     rd_cnt;
  logic [width_exp-1:0] max_exp;
  logic [width_exp-1:0] max_next;
  logic [width_exp-1:0] scale_q;

  logic [width_exp-1:0] exp_mem [block_size];
  logic [width_man-1:0] man_mem [block_size];

  logic                 acc;
  logic                 hs;
  logic                 wr_last;
  logic                 rd_last;
  logic [width_exp-1:0] rd_exp;
  logic [width_man-1:0] rd_man;
  logic [width_exp:0]   diff;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // ready/valid are registered flags; they never depend on i_valid/i_ready
  // in the same cycle, and the two sides are never open at the same time.
  assign acc     = (state_q == FILL) && ready_q && i_valid;
  assign hs      = (state_q == DRAIN) && valid_q && i_ready;
  assign wr_last = (wr_cnt == last_idx);
  assign rd_last = (rd_cnt == last_idx);

  // Zero mantissas carry no magnitude, so they must not raise the scale.
  assign max_next = ((i_man != '0) && (i_exp > max_exp)) ? i_exp : max_exp;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (acc && wr_last) state_d = DRAIN;
      DRAIN:   if (hs && rd_last)  state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= FILL;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      max_exp <= '0;
      scale_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == FILL);
      valid_q <= (state_d == DRAIN);
      if (acc) begin
        max_exp <= max_next;
        if (wr_last) begin
          wr_cnt  <= '0;
          scale_q <= max_next;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (hs) begin
        if (rd_last) begin
          rd_cnt  <= '0;
          max_exp <= '0;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  // Block buffer; contents are only observed through the gated outputs.
  always_ff @(posedge i_clk) begin
    if (acc) begin
      exp_mem[wr_cnt] <= i_exp;
      man_mem[wr_cnt] <= i_man;
    end
  end

  assign rd_exp = exp_mem[rd_cnt];
  assign rd_man = man_mem[rd_cnt];
  assign diff   = {1'b0, scale_q} - {1'b0, rd_exp};

  assign o_ready = ready_q;
  assign o_valid = valid_q;

  // Outputs stay at zero whenever no element is being presented.
  always_comb begin
    o_man   = '0;
    o_shift = '0;
    o_scale = '0;
    o_last  = 1'b0;
    if (valid_q) begin
      o_man   = rd_man;
      o_scale = scale_q;
      o_last  = rd_last;
      if (rd_man != '0) begin
        if (32'(diff) > shift_max) o_shift = shift_max[width_shift-1:0];
        else                       o_shift = width_shift'(diff);
      end
    end
  end

endmodule

// File: tb/tb_mx_block_scaler.sv
// Directed bench for mx_block_scaler: table of blocks plus backpressure,
// mid-operation reset, saturation and throughput sequences.
module tb_mx_block_scaler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] i_exp;
  logic [8:0] i_man;

  logic       m_ready, m_valid, m_last;
  logic [8:0] m_man;
  logic [7:0] m_shift, m_scale;

  logic       s_ready, s_valid, s_last;
  logic [8:0] s_man;
  logic [2:0] s_shift;
  logic [7:0] s_scale;

  mx_block_scaler #(.block_size(4), .width_exp(8), .width_man(9), .width_shift(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(m_ready),
    .i_exp(i_exp), .i_man(i_man), .o_valid(m_valid), .i_ready(i_ready),
    .o_man(m_man), .o_shift(m_shift), .o_scale(m_scale), .o_last(m_last)
  );

  mx_block_scaler #(.block_size(4), .width_exp(8), .width_man(9), .width_shift(3)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(s_ready),
    .i_exp(i_exp), .i_man(i_man), .o_valid(s_valid), .i_ready(i_ready),
    .o_man(s_man), .o_shift(s_shift), .o_scale(s_scale), .o_last(s_last)
  );

  // sel picks which instance is being observed; both run in lockstep
  logic       sel;
  logic       cur_ready, cur_valid, cur_last;
  logic [8:0] cur_man;
  logic [7:0] cur_shift, cur_scale;

  always_comb begin
    cur_ready = m_ready;
    cur_valid = m_valid;
    cur_last  = m_last;
    cur_man   = m_man;
    cur_shift = m_shift;
    cur_scale = m_scale;
    if (sel) begin
      cur_ready = s_ready;
      cur_valid = s_valid;
      cur_last  = s_last;
      cur_man   = s_man;
      cur_shift = {5'd0, s_shift};
      cur_scale = s_scale;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vectors ----------------
  typedef struct packed {
    logic [3:0][7:0] exps;
    logic [3:0][8:0] mans;
    logic [7:0]      scale;
    logic [3:0][7:0] shifts;
  } vec_t;

  function automatic vec_t mk(int e0, int e1, int e2, int e3,
                              int m0, int m1, int m2, int m3,
                              int sc, int s0, int s1, int s2, int s3);
    vec_t v;
    v.exps[0] = 8'(e0); v.exps[1] = 8'(e1); v.exps[2] = 8'(e2); v.exps[3] = 8'(e3);
    v.mans[0] = 9'(m0); v.mans[1] = 9'(m1); v.mans[2] = 9'(m2); v.mans[3] = 9'(m3);
    v.scale = 8'(sc);
    v.shifts[0] = 8'(s0); v.shifts[1] = 8'(s1); v.shifts[2] = 8'(s2); v.shifts[3] = 8'(s3);
    return v;
  endfunction

  vec_t vecs[5];
  vec_t vpart;

  // ---------------- scoreboard ----------------
  logic [25:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int first_acc;
  bit hold_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int t = 0;
    while (cur_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("o_ready_wait", 32'(cur_ready), 32'd1);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (cur_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("o_valid_wait", 32'(cur_valid), 32'd1);
  endtask

  task automatic drive_block(input vec_t v, input int n, input bit push);
    for (int i = 0; i < n; i++) begin
      wait_ready();
      if (i == 0) first_acc = cyc;
      i_valid = 1'b1;
      i_exp   = v.exps[i];
      i_man   = v.mans[i];
      @(negedge clk);
    end
    i_valid = 1'b0;
    if (push)
      for (int i = 0; i < 4; i++)
        exp_q.push_back({v.mans[i], v.shifts[i], v.scale, (i == 3)});
    if (n == 4) check("valid_after_last_accept", 32'({cur_valid, cur_ready}), 32'b10);
  endtask

  task automatic collect(input int n, input int stall_idx);
    logic [25:0] act;
    logic [25:0] exp;
    for (int i = 0; i < n; i++) begin
      wait_valid();
      act = {cur_man, cur_shift, cur_scale, cur_last};
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else exp = '1;
      check($sformatf("elem%0d", i), 32'(act), 32'(exp));
      if (i == stall_idx) begin
        i_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_hold", 32'({cur_valid, cur_man, cur_shift, cur_scale, cur_last}),
                32'({1'b1, act}));
        end
      end
      i_ready = 1'b1;
      @(negedge clk);
    end
    if (!hold_ready) i_ready = 1'b0;
    if (n == 4) begin
      check("ready_after_drain", 32'({cur_valid, cur_ready}), 32'b01);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          32'({cur_valid, cur_ready, cur_man, cur_shift, cur_scale, cur_last}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'({cur_valid, cur_ready}), 32'b01);
    exp_q.delete();
  endtask

  // ---------------- test ----------------
  initial begin
    int t0;
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_exp = '0; i_man = '0;
    sel = 1'b0; hold_ready = 1'b0;

    //               exps              mans               scale shifts
    vecs[0] = mk(10, 12, 7, 12,     5, -3, 100, 1,      12,  2, 0, 5, 0);
    vecs[1] = mk(30, 9, 9, 9,       0, 4, -4, 1,        9,   0, 0, 0, 0);
    vecs[2] = mk(5, 6, 7, 8,        0, 0, 0, 0,         0,   0, 0, 0, 0);
    vecs[3] = mk(0, 255, 3, 100,    -256, 1, 255, -1,   255, 255, 0, 252, 155);
    vecs[4] = mk(20, 1, 20, 13,     3, 2, -1, 9,        20,  0, 7, 0, 7);
    vpart   = mk(200, 201, 0, 0,    7, 7, 0, 0,         0,   0, 0, 0, 0);

    @(negedge clk);
    do_reset();

    for (int k = 0; k < 4; k++) begin
      drive_block(vecs[k], 4, 1'b1);
      collect(4, -1);
    end

    // saturation, observed on the width_shift=3 instance
    sel = 1'b1;
    drive_block(vecs[4], 4, 1'b1);
    collect(4, -1);
    sel = 1'b0;

    // backpressure on element 2
    drive_block(vecs[0], 4, 1'b1);
    collect(4, 2);

    // reset after 2 of 4 accepts; stale high exponents must not leak
    drive_block(vpart, 2, 1'b0);
    do_reset();
    drive_block(vecs[0], 4, 1'b1);
    collect(4, -1);

    // reset during drain
    drive_block(vecs[3], 4, 1'b1);
    collect(1, -1);
    do_reset();
    drive_block(vecs[1], 4, 1'b1);
    collect(4, -1);

    // back-to-back blocks with i_ready held high
    hold_ready = 1'b1;
    i_ready = 1'b1;
    drive_block(vecs[0], 4, 1'b1);
    t0 = first_acc;
    collect(4, -1);
    drive_block(vecs[1], 4, 1'b1);
    check("block_period", 32'(first_acc - t0), 32'd8);
    collect(4, -1);
    hold_ready = 1'b0;
    i_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
